// File: rtl/shift_mux_pkg.sv
// Shared constants, default parameter values and the truncating-shift helper
// for the shift_mux_pipe selector.
package shift_mux_pkg;

  localparam int CNT_W = 16;
  localparam int MAX_W = 64;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_SHIFT = 3;
  localparam logic [15:0] DEF_SHIFT_MASK = 16'h0001;

  // Returns {result, ovf}: result is (word << amount) cut to width bits,
  // ovf flags any nonzero bit among the top amount bits that fall off.
  function automatic logic [MAX_W:0] shl_trunc(
    input logic [MAX_W-1:0] word,
    input int amount,
    input int width
  );
    logic [MAX_W-1:0] keep;
    logic [MAX_W-1:0] res;
    logic [MAX_W-1:0] lost;
    keep = '0;
    lost = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) keep[i] = 1'b1;
      if ((i >= width - amount) && (i < width)) lost[i] = word[i];
    end
    res = (word << amount) & keep;
    return {res, |lost};
  endfunction

endpackage

// File: rtl/shift_mux_stage.sv
// Generic valid/ready register slice: one payload register plus valid,
// with ready passed back combinationally.
module shift_mux_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  // Handshake: a beat moves when valid && ready on the same rising edge;
  // the slice accepts whenever it is empty or is being drained this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_mux_pipe.sv
// Two-stage N-channel selector with a fixed per-channel left shift.
// Define SHIFT_MUX_PIPE_OVF_EN to build the shifted-out overflow flag.
module shift_mux_pipe
  import shift_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SHIFT = DEF_SHIFT,
  parameter logic [NUM_CH-1:0] SHIFT_MASK = NUM_CH'(DEF_SHIFT_MASK)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*WIDTH-1:0]   in_data,
  input  logic [$clog2(NUM_CH)-1:0] in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_ovf,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          out_cnt
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int P1_W = CH_W + 1 + WIDTH;

  logic [WIDTH-1:0] sel_word;
  logic             sel_mask;
  logic [P1_W-1:0]  s1_in;
  logic [P1_W-1:0]  s1_q;
  logic             v1;
  logic             s2_ready;
  logic [CH_W-1:0]  s1_ch;
  logic             s1_mask;
  logic [WIDTH-1:0] s1_word;
  logic [WIDTH-1:0] shl_word;
  logic [WIDTH-1:0] res_word;

  // Out-of-range selects (non-power-of-2 NUM_CH) fall through to zero data.
  always_comb begin
    sel_word = '0;
    sel_mask = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_sel == CH_W'(i)) begin
        sel_word = in_data[i*WIDTH +: WIDTH];
        sel_mask = SHIFT_MASK[i];
      end
    end
  end

  assign s1_in = {in_sel, sel_mask, sel_word};

  shift_mux_stage #(.W(P1_W)) u_sel_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (s1_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (s1_q),
    .out_valid (v1),
    .out_ready (s2_ready)
  );

  assign {s1_ch, s1_mask, s1_word} = s1_q;

`ifdef SHIFT_MUX_PIPE_OVF_EN
  localparam int P2_W = CH_W + 1 + WIDTH;

  logic            shl_ovf;
  logic            res_ovf;
  logic [P2_W-1:0] s2_in;
  logic [P2_W-1:0] s2_q;

  assign {shl_word, shl_ovf} = (WIDTH+1)'(shl_trunc(MAX_W'(s1_word), SHIFT, WIDTH));
  assign res_word = s1_mask ? shl_word : s1_word;
  assign res_ovf  = s1_mask & shl_ovf;
  assign s2_in    = {s1_ch, res_ovf, res_word};
  assign {out_ch, out_ovf, out_data} = s2_q;
`else
  localparam int P2_W = CH_W + WIDTH;

  logic [P2_W-1:0] s2_in;
  logic [P2_W-1:0] s2_q;

  assign shl_word = WIDTH'(shl_trunc(MAX_W'(s1_word), SHIFT, WIDTH) >> 1);
  assign res_word = s1_mask ? shl_word : s1_word;
  assign s2_in    = {s1_ch, res_word};
  assign {out_ch, out_data} = s2_q;
  assign out_ovf  = 1'b0;
`endif

  shift_mux_stage #(.W(P2_W)) u_shift_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (s2_in),
    .in_valid  (v1),
    .in_ready  (s2_ready),
    .out_data  (s2_q),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (out_valid && out_ready) begin
      out_cnt <= out_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_shift_mux_pipe.sv
// Scoreboard bench for shift_mux_pipe: directed cases, streaming,
// backpressure, counter wrap and mid-flight reset.
module tb_shift_mux_pipe;

  localparam int WIDTH = 8;
  localparam int NUM_CH = 4;
  localparam int SHIFT = 3;
  localparam logic [NUM_CH-1:0] SHIFT_MASK = 4'b0001;
  localparam int CH_W = 2;
  localparam int EW = CH_W + 1 + WIDTH;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH*WIDTH-1:0] in_data = '0;
  logic [CH_W-1:0]         in_sel = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [CH_W-1:0]         out_ch;
  logic                    out_ovf;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [15:0]             out_cnt;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int xfer_cnt = 0;
  int run = 0;
  int max_run = 0;
  bit prev_xfer = 1'b0;

  shift_mux_pipe #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .SHIFT(SHIFT), .SHIFT_MASK(SHIFT_MASK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] model(input logic [NUM_CH*WIDTH-1:0] d,
                                          input logic [CH_W-1:0] s);
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] r;
    logic m;
    logic o;
    w = (int'(s) < NUM_CH) ? d[int'(s)*WIDTH +: WIDTH] : '0;
    m = (int'(s) < NUM_CH) ? SHIFT_MASK[s] : 1'b0;
    r = m ? WIDTH'(int'(w) * (2 ** SHIFT)) : w;
    o = 1'b0;
`ifdef SHIFT_MUX_PIPE_OVF_EN
    o = m && ((int'(w) >> (WIDTH - SHIFT)) != 0);
`endif
    return {s, o, r};
  endfunction

  // Monitor: push on input accept, pop and compare on output transfer.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && in_valid && in_ready) exp_q.push_back(model(in_data, in_sel));
    if (rst_n && out_valid && out_ready) begin
      xfer_cnt++;
      run = prev_xfer ? run + 1 : 1;
      if (run > max_run) max_run = run;
      prev_xfer = 1'b1;
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("out_word", 32'({out_ch, out_ovf, out_data}), 32'(e));
      end
    end else begin
      prev_xfer = 1'b0;
    end
  end

  task automatic send(input logic [NUM_CH*WIDTH-1:0] d, input logic [CH_W-1:0] s);
    bit ok;
    in_data = d;
    in_sel = s;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("send_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check(tag, 32'(exp_q.size()), 32'(0));
    @(posedge clk); #1;
  endtask

  function automatic logic [NUM_CH*WIDTH-1:0] rand_data();
    return {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
  endfunction

  // Single request with explicit 2-cycle latency and result check.
  task automatic one_shot(input string tag, input logic [NUM_CH*WIDTH-1:0] d,
                          input logic [CH_W-1:0] s, input logic [WIDTH-1:0] exp_data);
    send(d, s);
    idle();
    @(negedge clk);
    check({tag, "_lat1"}, 32'(out_valid), 32'(0));
    @(negedge clk);
    check({tag, "_lat2"}, 32'(out_valid), 32'(1));
    check({tag, "_data"}, 32'(out_data), 32'(exp_data));
    check({tag, "_ch"}, 32'(out_ch), 32'(s));
    @(posedge clk); #1;
    drain({tag, "_drain"});
  endtask

  initial begin
    logic [NUM_CH*WIDTH-1:0] d;
    logic [WIDTH-1:0] held;
    int n;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_ch", 32'(out_ch), 32'(0));
    check("rst_out_ovf", 32'(out_ovf), 32'(0));
    check("rst_out_cnt", 32'(out_cnt), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Masked channel 0: 0x15 << 3 = 0xA8, no top bits lost.
    one_shot("ch0", {8'h00, 8'h00, 8'h00, 8'h15}, 2'd0, 8'hA8);
    check("ch0_ovf", 32'(out_ovf), 32'(0));
    check("ch0_cnt", 32'(out_cnt), 32'(1));
    one_shot("ch2", {8'h11, 8'h5A, 8'h22, 8'h33}, 2'd2, 8'h5A);
    // Masked with top bits set: 0xF1 << 3 = 0x88.
    one_shot("ch0_hi", {8'h00, 8'h00, 8'h00, 8'hF1}, 2'd0, 8'h88);
    one_shot("ch3", {8'hC3, 8'h00, 8'h00, 8'hFF}, 2'd3, 8'hC3);

    // Back-to-back stream must deliver 8 transfers on consecutive cycles.
    max_run = 0;
    for (int i = 0; i < 8; i++) send(rand_data(), CH_W'(i % 4));
    idle();
    drain("stream_drain");
    check("stream_run", 32'(max_run), 32'(8));

    // Backpressure: two accepted, third stalls, outputs hold.
    out_ready = 1'b0;
    d = rand_data();
    held = model(d, 2'd0)[WIDTH-1:0];
    send(d, 2'd0);
    send(rand_data(), 2'd1);
    in_data = rand_data();
    in_sel = 2'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_hold_data", 32'(out_data), 32'(held));
      check("bp_hold_ch", 32'(out_ch), 32'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(in_data, in_sel);
    idle();
    drain("bp_drain");

    // Random mix with occasional stall cycles.
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        idle();
        out_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
      send(rand_data(), CH_W'($urandom_range(0, 3)));
    end
    idle();
    drain("rand_drain");
    check("cnt_track", 32'(out_cnt), 32'(xfer_cnt));

    // Walk the counter to 0xFFFF, then one more transfer wraps it.
    n = 65535 - xfer_cnt;
    for (int i = 0; i < n; i++) send(rand_data(), CH_W'($urandom_range(0, 3)));
    idle();
    drain("wrap_drain");
    check("cnt_ffff", 32'(out_cnt), 32'h0000FFFF);
    send(rand_data(), 2'd1);
    idle();
    drain("wrap_last_drain");
    check("cnt_wrap", 32'(out_cnt), 32'h00000000);

    // Reset with both stages full drops everything.
    out_ready = 1'b0;
    send(rand_data(), 2'd0);
    send(rand_data(), 2'd3);
    idle();
    check("full_in_ready", 32'(in_ready), 32'(0));
    check("full_out_valid", 32'(out_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_in_ready", 32'(in_ready), 32'(1));
    check("mid_rst_cnt", 32'(out_cnt), 32'(0));
    exp_q.delete();
    xfer_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_no_replay", 32'(out_cnt), 32'(0));
    send(rand_data(), 2'd2);
    idle();
    drain("post_rst_drain");
    check("post_rst_cnt", 32'(out_cnt), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
